// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port for loads and stores,
// stalls upstream while an access is in flight, and registers results into MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_mem_to_reg_wr,
  input  logic        ex_mem_mem_wr_en,
  input  logic        ex_mem_reg_wr_en,
  input  logic [4:0]  ex_mem_reg_wr_addr,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_mem_wr_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        mem_wb_reg_wr_en,
  output logic        mem_wb_mem_to_reg_wr,
  output logic [4:0]  mem_wb_reg_wr_addr,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_rd_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              wb_reg_wr_en_q, wb_reg_wr_en_d;
  logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]        wb_reg_wr_addr_q, wb_reg_wr_addr_d;
  logic [31:0]       wb_alu_result_q, wb_alu_result_d;
  logic [31:0]       wb_rd_data_q, wb_rd_data_d;
  logic              stall_raw;
  logic              access;
  logic              timeout;

  assign access  = ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en;
  assign timeout = (state_q == ACCESS) && (cnt_q == CNT_LAST) && !dmem_ack;

  // NOTE: every signal driven here gets a default first, otherwise a path that
  // skips an assignment would infer a latch.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    we_d             = we_q;
    err_d            = err_q;
    stall_raw        = 1'b0;
    wb_reg_wr_en_d   = 1'b0;
    wb_mem_to_reg_d  = 1'b0;
    wb_reg_wr_addr_d = '0;
    wb_alu_result_d  = '0;
    wb_rd_data_d     = '0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall_raw = 1'b1;
          state_d   = ACCESS;
          cnt_d     = '0;
          addr_d    = ex_mem_alu_result;
          wdata_d   = ex_mem_mem_wr_data;
          we_d      = ex_mem_mem_wr_en;
        end else begin
          wb_reg_wr_en_d   = ex_mem_reg_wr_en;
          wb_mem_to_reg_d  = ex_mem_mem_to_reg_wr;
          wb_reg_wr_addr_d = ex_mem_reg_wr_addr;
          wb_alu_result_d  = ex_mem_alu_result;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout) begin
          // Upstream is still holding the instruction, so it is captured here.
          wb_reg_wr_en_d   = ex_mem_reg_wr_en & dmem_ack;
          wb_mem_to_reg_d  = ex_mem_mem_to_reg_wr;
          wb_reg_wr_addr_d = ex_mem_reg_wr_addr;
          wb_alu_result_d  = ex_mem_alu_result;
          wb_rd_data_d     = (dmem_ack && !we_q) ? dmem_rdata : 32'h0;
          err_d            = err_q | timeout;
          state_d          = IDLE;
          cnt_d            = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      we_q             <= 1'b0;
      err_q            <= 1'b0;
      wb_reg_wr_en_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_wr_addr_q <= '0;
      wb_alu_result_q  <= '0;
      wb_rd_data_q     <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      we_q             <= we_d;
      err_q            <= err_d;
      wb_reg_wr_en_q   <= wb_reg_wr_en_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_reg_wr_addr_q <= wb_reg_wr_addr_d;
      wb_alu_result_q  <= wb_alu_result_d;
      wb_rd_data_q     <= wb_rd_data_d;
    end
  end

  assign dmem_req             = (state_q == ACCESS);
  assign dmem_we              = we_q;
  assign dmem_addr            = addr_q;
  assign dmem_wdata           = wdata_q;
  assign mem_stall            = stall_raw & ~reset;
  assign mem_err              = err_q;
  assign mem_wb_reg_wr_en     = wb_reg_wr_en_q;
  assign mem_wb_mem_to_reg_wr = wb_mem_to_reg_q;
  assign mem_wb_reg_wr_addr   = wb_reg_wr_addr_q;
  assign mem_wb_alu_result    = wb_alu_result_q;
  assign mem_wb_rd_data       = wb_rd_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed load/store/timeout/reset scenarios,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en, ex_mem_reg_wr_en;
  logic [4:0]  ex_mem_reg_wr_addr;
  logic [31:0] ex_mem_alu_result, ex_mem_mem_wr_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, mem_err;
  logic        mem_wb_reg_wr_en, mem_wb_mem_to_reg_wr;
  logic [4:0]  mem_wb_reg_wr_addr;
  logic [31:0] mem_wb_alu_result, mem_wb_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ex_mem_mem_to_reg_wr (ex_mem_mem_to_reg_wr),
    .ex_mem_mem_wr_en     (ex_mem_mem_wr_en),
    .ex_mem_reg_wr_en     (ex_mem_reg_wr_en),
    .ex_mem_reg_wr_addr   (ex_mem_reg_wr_addr),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_mem_wr_data   (ex_mem_mem_wr_data),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .mem_stall            (mem_stall),
    .mem_err              (mem_err),
    .mem_wb_reg_wr_en     (mem_wb_reg_wr_en),
    .mem_wb_mem_to_reg_wr (mem_wb_mem_to_reg_wr),
    .mem_wb_reg_wr_addr   (mem_wb_reg_wr_addr),
    .mem_wb_alu_result    (mem_wb_alu_result),
    .mem_wb_rd_data       (mem_wb_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // waited < 0: no transaction outstanding; otherwise cycles already spent waiting.
  int          waited = -1;
  bit          started = 1'b0;
  logic [31:0] pend_addr = '0, pend_wdata = '0;
  logic        pend_we = 1'b0;
  logic        e_err = 1'b0;
  logic        e_wb_we = 1'b0, e_wb_m2r = 1'b0;
  logic [4:0]  e_wb_rd_addr = '0;
  logic [31:0] e_wb_alu = '0, e_wb_data = '0;

  function automatic logic model_stall();
    if (reset) return 1'b0;
    if (waited < 0) return ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en;
    return !dmem_ack && (waited != T - 1);
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      waited <= -1; pend_addr <= '0; pend_wdata <= '0; pend_we <= 1'b0; e_err <= 1'b0;
      e_wb_we <= 1'b0; e_wb_m2r <= 1'b0; e_wb_rd_addr <= '0; e_wb_alu <= '0; e_wb_data <= '0;
    end else if (waited < 0 && (ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en)) begin
      waited <= 0; pend_addr <= ex_mem_alu_result; pend_wdata <= ex_mem_mem_wr_data;
      pend_we <= ex_mem_mem_wr_en;
      e_wb_we <= 1'b0; e_wb_m2r <= 1'b0; e_wb_rd_addr <= '0; e_wb_alu <= '0; e_wb_data <= '0;
    end else if (waited < 0 || dmem_ack || waited == T - 1) begin
      // Instruction retires into MEM/WB: plain op, completed access, or timed out.
      e_wb_we      <= ex_mem_reg_wr_en && (waited < 0 || dmem_ack);
      e_wb_m2r     <= ex_mem_mem_to_reg_wr;
      e_wb_rd_addr <= ex_mem_reg_wr_addr;
      e_wb_alu     <= ex_mem_alu_result;
      e_wb_data    <= (waited >= 0 && dmem_ack && !pend_we) ? dmem_rdata : 32'h0;
      if (waited >= 0 && !dmem_ack) e_err <= 1'b1;
      waited <= -1;
    end else begin
      waited <= waited + 1;
      e_wb_we <= 1'b0; e_wb_m2r <= 1'b0; e_wb_rd_addr <= '0; e_wb_alu <= '0; e_wb_data <= '0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("mem_stall", mem_stall, model_stall());
      check("dmem_req", dmem_req, waited >= 0);
      check("dmem_we", dmem_we, pend_we);
      check("dmem_addr", dmem_addr, pend_addr);
      check("dmem_wdata", dmem_wdata, pend_wdata);
      check("mem_err", mem_err, e_err);
      check("wb_reg_wr_en", mem_wb_reg_wr_en, e_wb_we);
      check("wb_mem_to_reg", mem_wb_mem_to_reg_wr, e_wb_m2r);
      check("wb_reg_wr_addr", mem_wb_reg_wr_addr, e_wb_rd_addr);
      check("wb_alu_result", mem_wb_alu_result, e_wb_alu);
      check("wb_rd_data", mem_wb_rd_data, e_wb_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        s_stall, s_req, s_we;
  logic [31:0] s_addr, s_wdata;

  task automatic op(input logic ld, input logic st, input logic rwe, input logic [4:0] ra,
                    input logic [31:0] alu, input logic [31:0] wd);
    ex_mem_mem_to_reg_wr = ld;
    ex_mem_mem_wr_en     = st;
    ex_mem_reg_wr_en     = rwe;
    ex_mem_reg_wr_addr   = ra;
    ex_mem_alu_result    = alu;
    ex_mem_mem_wr_data   = wd;
  endtask

  task automatic nop();
    op(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  // One clock: apply ack/rdata, snapshot outputs mid-cycle, return just after the edge.
  task automatic cyc(input logic a, input logic [31:0] rd);
    dmem_ack   = a;
    dmem_rdata = rd;
    @(negedge clk);
    s_stall = mem_stall; s_req = dmem_req; s_we = dmem_we;
    s_addr  = dmem_addr; s_wdata = dmem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int n_stall, n_req;

  initial begin
    reset = 1'b1;
    nop();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    @(posedge clk); #1;
    do_reset();
    check("rst_req", dmem_req, 1'b0);
    check("rst_err", mem_err, 1'b0);
    check("rst_wb_we", mem_wb_reg_wr_en, 1'b0);

    // 1: non-memory op
    op(1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0);
    cyc(1'b0, 32'hDEAD_BEEF);
    check("t1_stall", s_stall, 1'b0);
    nop();
    check("t1_alu", mem_wb_alu_result, 32'h10);
    check("t1_addr", mem_wb_reg_wr_addr, 5'd5);
    check("t1_we", mem_wb_reg_wr_en, 1'b1);
    check("t1_rd", mem_wb_rd_data, 32'h0);

    // 2: load acked on 3rd ACCESS cycle
    op(1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0);
    n_stall = 0; n_req = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(c == 3, (c == 3) ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
      n_stall += int'(s_stall);
      n_req   += int'(s_req);
      if (c < 3) check("t2_bubble", mem_wb_reg_wr_en, 1'b0);
      if (c >= 1) begin
        check("t2_we", s_we, 1'b0);
        check("t2_addr", s_addr, 32'h100);
      end
    end
    nop(); dmem_ack = 1'b0;
    check("t2_stall_cycles", n_stall, 3);
    check("t2_req_cycles", n_req, 3);
    check("t2_rd", mem_wb_rd_data, 32'hCAFE_F00D);
    check("t2_m2r", mem_wb_mem_to_reg_wr, 1'b1);
    check("t2_addr_wb", mem_wb_reg_wr_addr, 5'd7);

    // 3: store then load back to back
    op(1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h1234_5678);
    cyc(1'b0, 32'h0);
    check("t3_idle_stall", s_stall, 1'b1);
    check("t3_idle_req", s_req, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF);
    check("t3_st_req", s_req, 1'b1);
    check("t3_st_we", s_we, 1'b1);
    check("t3_st_wdata", s_wdata, 32'h1234_5678);
    check("t3_st_stall", s_stall, 1'b0);
    check("t3_st_rd", mem_wb_rd_data, 32'h0);
    op(1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0);
    cyc(1'b0, 32'h0);
    check("t3_gap_req", s_req, 1'b0);
    check("t3_ld_idle_stall", s_stall, 1'b1);
    cyc(1'b1, 32'hA5A5_0001);
    check("t3_ld_req", s_req, 1'b1);
    check("t3_ld_we", s_we, 1'b0);
    check("t3_ld_addr", s_addr, 32'h300);
    nop(); dmem_ack = 1'b0;
    check("t3_ld_rd", mem_wb_rd_data, 32'hA5A5_0001);
    check("t3_ld_wb_addr", mem_wb_reg_wr_addr, 5'd9);

    // 4: timeout
    op(1'b1, 1'b0, 1'b1, 5'd3, 32'h400, 32'h0);
    cyc(1'b0, 32'h0);
    n_req = 0;
    for (int c = 0; c < T; c++) begin
      cyc(1'b0, 32'hDEAD_BEEF);
      n_req += int'(s_req);
      if (c == T - 1) check("t4_last_stall", s_stall, 1'b0);
    end
    nop();
    check("t4_req_cycles", n_req, T);
    check("t4_err", mem_err, 1'b1);
    check("t4_wb_we", mem_wb_reg_wr_en, 1'b0);
    check("t4_wb_addr", mem_wb_reg_wr_addr, 5'd3);
    check("t4_wb_rd", mem_wb_rd_data, 32'h0);
    cyc(1'b0, 32'h0);
    check("t4_req_after", s_req, 1'b0);
    op(1'b0, 1'b0, 1'b1, 5'd1, 32'h55, 32'h0);
    cyc(1'b0, 32'h0);
    op(1'b1, 1'b0, 1'b1, 5'd2, 32'h404, 32'h0);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h0000_0777);
    nop(); dmem_ack = 1'b0;
    check("t4_err_sticky", mem_err, 1'b1);
    check("t4_ld_rd", mem_wb_rd_data, 32'h0000_0777);
    do_reset();
    check("t4_err_cleared", mem_err, 1'b0);

    // 5: ack on the final allowed cycle
    op(1'b1, 1'b0, 1'b1, 5'd4, 32'h500, 32'h0);
    cyc(1'b0, 32'h0);
    for (int c = 0; c < T; c++) begin
      cyc(c == T - 1, (c == T - 1) ? 32'h5EED_0004 : 32'hDEAD_BEEF);
      if (c == T - 1) check("t5_last_stall", s_stall, 1'b0);
    end
    nop(); dmem_ack = 1'b0;
    check("t5_err", mem_err, 1'b0);
    check("t5_rd", mem_wb_rd_data, 32'h5EED_0004);
    check("t5_we", mem_wb_reg_wr_en, 1'b1);

    // 6: reset on 2nd ACCESS cycle, late ack
    op(1'b1, 1'b0, 1'b1, 5'd6, 32'h600, 32'h0);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    reset = 1'b1;
    cyc(1'b0, 32'h0);
    check("t6_rst_stall", s_stall, 1'b0);
    check("t6_rst_req", s_req, 1'b1);
    reset = 1'b0;
    nop();
    cyc(1'b1, 32'hBAD0_BAD0);
    check("t6_ack_req", s_req, 1'b0);
    check("t6_ack_stall", s_stall, 1'b0);
    check("t6_addr", s_addr, 32'h0);
    dmem_ack = 1'b0;
    check("t6_err", mem_err, 1'b0);
    check("t6_wb_we", mem_wb_reg_wr_en, 1'b0);
    check("t6_wb_rd", mem_wb_rd_data, 32'h0);
    check("t6_wb_alu", mem_wb_alu_result, 32'h0);
    cyc(1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs, performs load/store through a request/acknowledge data-memory port, and registers results into the MEM/WB pipeline register.
- Holds the upstream pipeline via mem_stall for the duration of each memory access.
- Bounds every access with a timeout and reports a sticky error.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of ACCESS-state cycles waiting for dmem_ack (legal range ≥2); counter width = clog2(TIMEOUT_CYCLES).

Ports:
- clk in 1: rising-edge clock
- reset in 1: synchronous, active-high reset
- ex_mem_mem_to_reg_wr in 1: instruction is a load
- ex_mem_mem_wr_en in 1: instruction is a store
- ex_mem_reg_wr_en in 1: instruction writes the register file
- ex_mem_reg_wr_addr in 5: destination register
- ex_mem_alu_result in 32: memory address, or ALU result for non-memory ops
- ex_mem_mem_wr_data in 32: store data
- dmem_req out 1: memory request
- dmem_we out 1: 1 = write, 0 = read
- dmem_addr out 32: request address
- dmem_wdata out 32: write data
- dmem_rdata in 32: read data, valid when dmem_ack=1
- dmem_ack in 1: access complete
- mem_stall out 1: freeze PC/IF/ID/EX registers this cycle
- mem_err out 1: sticky timeout flag
- mem_wb_reg_wr_en out 1
- mem_wb_mem_to_reg_wr out 1
- mem_wb_reg_wr_addr out 5
- mem_wb_alu_result out 32
- mem_wb_rd_data out 32: load data

Behaviour:
- access = ex_mem_mem_to_reg_wr | ex_mem_mem_wr_en. If both are 1, the operation is a store.
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE, access=0:
  - mem_stall=0.
  - At the next edge MEM/WB captures the ex_mem_* values; mem_wb_rd_data=0. Latency 1 cycle.
- IDLE, access=1:
  - mem_stall=1 (combinational); MEM/WB loads a bubble (all mem_wb_* = 0).
  - At the edge, dmem_addr, dmem_wdata and dmem_we are captured from the inputs, the counter is cleared, and the FSM goes to ACCESS.
- ACCESS:
  - dmem_req=1 (registered state decode); dmem_addr/dmem_wdata/dmem_we are stable from the captured registers.
  - mem_stall = ~dmem_ack & ~timeout, where timeout = (cnt == TIMEOUT_CYCLES-1) & ~dmem_ack.
- Ack in ACCESS:
  - mem_stall=0 in the same cycle.
  - At the edge MEM/WB captures the ex_mem_* values (still held by the stall) plus mem_wb_rd_data = dmem_rdata for loads, 0 for stores.
  - FSM returns to IDLE; the counter is cleared.
- No ack in ACCESS: the counter increments.
- Timeout:
  - Stall is released. At the edge MEM/WB captures the instruction with mem_wb_reg_wr_en forced to 0 and mem_wb_rd_data=0.
  - mem_err is set and held until reset. FSM returns to IDLE.
  - Maximum ACCESS residency is TIMEOUT_CYCLES cycles. An ack in the final cycle wins over the timeout (normal completion, no error).
- Back-to-back memory operations: after completion the FSM is in IDLE with the next instruction presented, so a new IDLE→ACCESS sequence starts. Minimum cost per memory operation is 2 cycles (1 IDLE stall + ≥1 ACCESS).
- dmem_ack while in IDLE is ignored. dmem_rdata is sampled only on an ack in ACCESS.
- Reset (also mid-ACCESS): at the edge all outputs go to 0 and the FSM goes to IDLE.
  - dmem_req is 0 from the first post-reset cycle; the aborted access is not completed and mem_err is cleared.
  - Ack arriving after reset is ignored.
- dmem_req/dmem_we/dmem_addr/dmem_wdata reset to 0. mem_stall is 0 during reset.

Test Plan:
1. Non-memory op: reg_wr_en=1, addr=5, alu_result=0x0000_0010, no access → mem_stall never 1; next cycle mem_wb_alu_result=0x10, mem_wb_reg_wr_addr=5, mem_wb_reg_wr_en=1, mem_wb_rd_data=0.
2. Load with 3-cycle ack delay: alu_result=0x100, ack with rdata=0xCAFE_F00D on the 3rd ACCESS cycle.
   - Required: mem_stall high 3 cycles (1 IDLE + 2 ACCESS), dmem_req high 3 cycles, dmem_we=0, dmem_addr=0x100.
   - MEM/WB shows bubbles, then mem_wb_rd_data=0xCAFE_F00D, mem_wb_mem_to_reg_wr=1.
3. Store followed immediately by a load, each acked on the first ACCESS cycle.
   - Required: store shows dmem_we=1, wdata=0x1234_5678; load issues from IDLE the following cycle.
   - Total 4 cycles; dmem_req deasserts for exactly 1 cycle between the two requests.
4. Timeout, TIMEOUT_CYCLES=4, load, no ack → dmem_req high exactly 4 cycles; mem_err=1 after the 4th; mem_wb_reg_wr_en=0; mem_err stays 1 across later normal ops.
5. Ack exactly on cycle 4 with TIMEOUT_CYCLES=4 → normal completion, mem_err=0, rd_data captured.
6. Reset asserted on the 2nd ACCESS cycle, ack delivered the following cycle → all outputs 0, FSM in IDLE, ack ignored, mem_err=0, no MEM/WB write.
